sync_adder_arb: RTL

Round-robin arbiter and sequencer that shares one `sync_adder` datapath between `NUM_REQ` requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester, drives the adder and holds the result on a single tagged response port until the consumer accepts it.
- It sits between several producer agents and the shared adder, and is the only driver of the adder's operand inputs.

---
 rtl/sync_adder_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/sync_adder.sv | 20 ++
 rtl/sync_adder_arb.sv | 108 ++++++++++
 4 files changed

// File: rtl/sync_adder_arb_pkg.sv
// Shared types and defaults for the sync_adder_arb slice.
// State encoding is kept as plain constants for compatibility with older tools.
package sync_adder_arb_pkg;

   localparam int unsigned ARB_DATA_WIDTH = 32;
   localparam int unsigned ARB_NUM_REQ    = 4;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t IDLE = 2'd0;
   localparam arb_state_t CALC = 2'd1;
   localparam arb_state_t RESP = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: one-hot grant plus encoded index, searching upward from ptr.
// SYNC_ADDER_ARB_FIXED_PRIO_EN selects fixed lowest-index priority and ignores ptr.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_idx
);

   int unsigned     k;
   logic [ID_W-1:0] kidx;
   logic            found;

`ifdef SYNC_ADDER_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;
`endif

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      k       = 0;
      kidx    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef SYNC_ADDER_ARB_FIXED_PRIO_EN
         k = i;
`else
         k = (32'(ptr) + i) % NUM_REQ;
`endif
         kidx = ID_W'(k);
         if (en && !found && req[kidx]) begin
            gnt[kidx] = 1'b1;
            gnt_idx   = kidx;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sync_adder.sv
// Registered (DATA_WIDTH+1)-bit adder with synchronous reset; carry lands in the MSB.
module sync_adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   sum
);

   always_ff @(posedge clk) begin
      if (rst) begin
         sum <= '0;
      end else begin
         sum <= {1'b0, a} + {1'b0, b};
      end
   end

endmodule

// File: rtl/sync_adder_arb.sv
// Shares one sync_adder between NUM_REQ requesters: IDLE grants, CALC adds, RESP holds result.
// Define SYNC_ADDER_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module sync_adder_arb
   import sync_adder_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
   parameter int unsigned NUM_REQ    = ARB_NUM_REQ,
   parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_W-1:0]               rsp_id,
   output logic [DATA_WIDTH:0]           rsp_sum,
   output logic                          busy
);

   arb_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, b_q;
   logic [ID_W-1:0]       tag_q;
   logic [ID_W-1:0]       ptr;
   logic [NUM_REQ-1:0]    gnt;
   logic [ID_W-1:0]       gnt_idx;
   logic [DATA_WIDTH:0]   sum;
   logic                  arb_en;
   logic                  accept;

   // Reset masks grants so req_ready reads 0 while rst is held.
   assign arb_en = (state_q == IDLE) && !rst;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req     (req_valid),
      .ptr     (ptr),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign accept    = |gnt;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = CALC;
         CALC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q   <= req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            b_q   <= req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            tag_q <= gnt_idx;
         end
      end
   end

`ifdef SYNC_ADDER_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   logic [ID_W-1:0] ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (state_q == RESP && rsp_ready) begin
         ptr_q <= (tag_q == ID_W'(NUM_REQ - 1)) ? '0 : tag_q + 1'b1;
      end
   end

   assign ptr = ptr_q;
`endif

   // Operands stay held through RESP, so the adder keeps re-registering the same sum.
   sync_adder #(
      .WIDTH (DATA_WIDTH)
   ) u_add (
      .clk (clk),
      .rst (rst),
      .a   (a_q),
      .b   (b_q),
      .sum (sum)
   );

   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = tag_q;
   assign rsp_sum   = rsp_valid ? sum : '0;

endmodule
